ppu_pixel_capture: RTL
======================

# ppu_pixel_capture

Consumer end of the PPU pixel stream. It samples `video`/`scanline`/`cycle` every `clk_ppu` and keeps only visible pixels. Each kept pixel is turned into a framebuffer write (linear address plus 6-bit palette index) and passed out through a small FIFO with a valid/ready write port, so downstream memory stalls are absorbed. It sits between the PPU and the framebuffer RAM that feeds the display scaler.

## Interface

Parameters:
- `FIFO_DEPTH`, default 16: write FIFO entries; power of two, minimum 4.

Ports:
- `clk_ppu` in 1: PPU clock, 5,369,318 Hz. All logic is on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `video` in 6: pixel palette index.
- `scanline` in 9: 0-261; visible rows are 0-239.
- `cycle` in 9: 0-340; visible dots are 1-256.
- `wr_valid` out 1: a framebuffer write is presented.
- `wr_ready` in 1: the framebuffer accepts the write.
- `wr_addr` out 16: `scanline*256 + (cycle-1)`, range 0-61439.
- `wr_data` out 6: palette index.
- `frame_done` out 1: one-cycle pulse when a frame's capture window closes.
- `frame_ok` out 1: updated with every `frame_done`; 1 if that frame was written with no pixel dropped.
- `busy` out 1: FIFO is not empty.

## Operation

- Input stage: `video`, `scanline`, `cycle` are registered once (stage S1). All decisions use the S1 values.
- A pixel is visible when S1 `scanline` ≤ 239 and 1 ≤ S1 `cycle` ≤ 256.
- Address is `{scanline[7:0], cycle[8:0]-1}[15:0]`. No multiplier.
- Frame start is S1 `scanline`=0 with `cycle`=0. Window end is S1 `scanline`=240 with `cycle`=0.
- State machine:
  - WAIT_SYNC (reset state): pushes nothing. Goes to RUN on frame start.
  - RUN: pushes every visible pixel. If a push is attempted while the FIFO is full, that pixel is dropped, the per-frame error bit is set and the state goes to DROP.
  - DROP: pushes nothing. Goes back to RUN on the next frame start and clears the error bit.
  - At window end in RUN or DROP: pulse `frame_done` and set `frame_ok` to the inverse of the error bit. Window end in WAIT_SYNC does not pulse.
- Frame start clears the error bit in every state.
- FIFO:
  - Synchronous, single clock. Entries are 22 bits (addr, data).
  - Count register runs 0..`FIFO_DEPTH`.
  - Push and pop in the same cycle leave the count unchanged, including when the FIFO is full; the push succeeds because a slot frees.
  - The FIFO keeps draining in every state.
- Output: `wr_valid` = FIFO not empty. A pop occurs when `wr_valid` && `wr_ready`. `wr_addr`/`wr_data` show the head entry and must stay stable while `wr_valid` && !`wr_ready`.

## Timing

- Values of every output while `resetn` is low:
  - `wr_valid`, `busy`, `frame_done`: 0
  - `frame_ok`: 0
  - `wr_addr`, `wr_data`: 0
  - FIFO empty, state WAIT_SYNC.
- Latency with the FIFO empty and `wr_ready`=1: a pixel sampled at edge N is in S1 after N, is written into the FIFO at N+1, and `wr_valid` is high after N+1 with that pixel's data.
- Sustained throughput is 1 write per clock. With `wr_ready` held high the FIFO never holds more than 1 entry.
- `frame_done` is high for exactly one cycle, after the edge that registers S1 = (240, 0). `frame_ok` changes on that same edge.
- If `resetn` is asserted mid-frame: FIFO contents are discarded, and nothing is written until the next full frame start.

## Configuration

- `PPU_CAPTURE_CROP_EN` defined: rows 0-7 and 232-239 are treated as not visible and are never written. Addresses of the remaining rows are unchanged. `frame_done`/`frame_ok` timing is unchanged.
- Not defined: all 240 rows are captured.

## Test plan

- Reset then free-running PPU timing, `wr_ready`=1:
  - No writes before the first frame start.
  - Next frame gives exactly 61440 writes, addresses 0..61439 ascending, each data equal to the driven `video`.
  - `frame_done` gives one pulse with `frame_ok`=1.
- Pixel (scanline 5, cycle 1, video 0x21) with an empty FIFO → `wr_valid` high 2 edges after it is driven, `wr_addr`=0x0500, `wr_data`=0x21.
- Hold `wr_ready`=0 during row 10:
  - After `FIFO_DEPTH` pushes the next pixel is dropped and the state goes to DROP.
  - The frame reports `frame_ok`=0.
  - Once `wr_ready` is released, the following frame writes all 61440 pixels and reports `frame_ok`=1.
- Full FIFO with `wr_ready`=1 and an arriving pixel in the same cycle → no drop, count stays at `FIFO_DEPTH`, head advances.
- Assert `resetn` at scanline 100:
  - All outputs go to their reset values immediately.
  - After release, no writes until scanline 0 / cycle 0.
- With `PPU_CAPTURE_CROP_EN` defined → no write to addresses below 2048 or at/above 59392, and 57344 writes per frame.

Source files
------------

// File: rtl/ppu_pixel_capture_if.sv
// Framebuffer write port of the PPU pixel capture block.
//   wr_valid : a write is presented (master -> slave)
//   wr_ready : the framebuffer accepts the write (slave -> master)
//   wr_addr  : linear framebuffer address, scanline*256 + dot
//   wr_data  : 6-bit palette index
interface ppu_pixel_capture_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [5:0]  wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/ppu_pixel_capture.sv
// Consumer end of the PPU pixel stream. Samples video/scanline/cycle every
// clk_ppu, keeps only visible pixels and turns each one into a framebuffer
// write that is buffered in a small FIFO so memory stalls are absorbed.
//
// Ports:
//   clk_ppu    : PPU clock, all logic on the rising edge
//   resetn     : asynchronous active-low reset
//   video      : palette index of the current dot
//   scanline   : 0-261, visible rows 0-239
//   cycle      : 0-340, visible dots 1-256
//   wr         : framebuffer write port (master side of ppu_pixel_capture_if)
//   frame_done : one-cycle pulse when a frame's capture window closes
//   frame_ok   : 1 if the last closed frame was written without a drop
//   busy       : write FIFO not empty
//
// Build option: define PPU_CAPTURE_CROP_EN to skip rows 0-7 and 232-239.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_SYNC | after reset; nothing pushed until a frame start is seen
// RUN       | every visible pixel is pushed into the write FIFO
// DROP      | a pixel was lost this frame; nothing pushed until next start
module ppu_pixel_capture #(
  parameter int FIFO_DEPTH = 16  // power of two, >= 4
) (
  input  logic                clk_ppu,
  input  logic                resetn,
  input  logic [5:0]          video,
  input  logic [8:0]          scanline,
  input  logic [8:0]          cycle,
  ppu_pixel_capture_if.master wr,
  output logic                frame_done,
  output logic                frame_ok,
  output logic                busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    RUN       = 2'd1,
    DROP      = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   err_q, err_d;
  logic   frame_ok_q;

  // Input stage. s1_vld keeps the reset value of S1 from looking like a
  // genuine (0,0) frame start on the first edge after reset.
  logic       s1_vld;
  logic [5:0] v1;
  logic [8:0] sl1, cy1;

  always_ff @(posedge clk_ppu or negedge resetn) begin
    if (!resetn) begin
      s1_vld <= 1'b0;
      v1     <= '0;
      sl1    <= '0;
      cy1    <= '0;
    end else begin
      s1_vld <= 1'b1;
      v1     <= video;
      sl1    <= scanline;
      cy1    <= cycle;
    end
  end

  logic        frame_start, window_end, row_ok, col_ok, visible;
  logic [15:0] pix_addr;

  assign frame_start = s1_vld && (sl1 == 9'd0)   && (cy1 == 9'd0);
  assign window_end  = s1_vld && (sl1 == 9'd240) && (cy1 == 9'd0);

`ifdef PPU_CAPTURE_CROP_EN
  assign row_ok = (sl1 >= 9'd8) && (sl1 <= 9'd231);
`else
  assign row_ok = (sl1 <= 9'd239);
`endif
  assign col_ok  = (cy1 >= 9'd1) && (cy1 <= 9'd256);
  assign visible = s1_vld && row_ok && col_ok;

  // Visible rows fit in 8 bits and cycle-1 in 0..255, so the address is a
  // plain concatenation; cycle 256 wraps to 0 in 8 bits and -1 gives 255.
  assign pix_addr = {sl1[7:0], cy1[7:0] - 8'd1};

  // FIFO
  logic [21:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, push, drop;
  logic [21:0]   head;

  assign full = (count == CW'(FIFO_DEPTH));
  assign pop  = wr.wr_valid && wr.wr_ready;

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    push       = 1'b0;
    drop       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      WAIT_SYNC: if (frame_start) state_d = RUN;
      RUN: begin
        if (visible) begin
          // a pop in the same cycle frees a slot even when full
          if (!full || pop) begin
            push = 1'b1;
          end else begin
            drop    = 1'b1;
            err_d   = 1'b1;
            state_d = DROP;
          end
        end
      end
      DROP:      if (frame_start) state_d = RUN;
      default:   state_d = WAIT_SYNC;
    endcase
    if (frame_start) err_d = 1'b0;
    if (window_end && (state_q != WAIT_SYNC)) frame_done = 1'b1;
  end

  // frame_ok shows the fresh result during the frame_done cycle and holds it
  // afterwards, so both change on the edge that registers the window end.
  assign frame_ok = frame_done ? ~err_q : frame_ok_q;

  always_ff @(posedge clk_ppu or negedge resetn) begin
    if (!resetn) begin
      state_q    <= WAIT_SYNC;
      err_q      <= 1'b0;
      frame_ok_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      frame_ok_q <= frame_ok;
    end
  end

  always_ff @(posedge clk_ppu) begin
    if (push) mem[wr_ptr] <= {pix_addr, v1};
  end

  always_ff @(posedge clk_ppu or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head is forced to zero while empty so the port reads 0 out of reset.
  assign head        = mem[rd_ptr];
  assign wr.wr_valid = (count != '0);
  assign wr.wr_addr  = wr.wr_valid ? head[21:6] : '0;
  assign wr.wr_data  = wr.wr_valid ? head[5:0]  : '0;
  assign busy        = wr.wr_valid;

endmodule
